slow_clk_monitor: RTL and testbench
===================================

SLOW_CLK_MONITOR -- requirements
Module: slow_clk_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on slow_in, legal range 2..4.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 250000000: clk cycles without an edge before loss is declared.
REQ-003 SHALL have parameter CNT_W, default 32: width of the cycle counter and of half_period.
REQ-004 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port slow_in, input, 1: asynchronous slow square wave, such as a divided clock.
REQ-007 SHALL have port rise_pulse, output, 1: one-cycle strobe per accepted rising edge.
REQ-008 SHALL have port fall_pulse, output, 1: one-cycle strobe per accepted falling edge.
REQ-009 SHALL have port half_period, output, CNT_W: clk cycles between the last two accepted edges.
REQ-010 SHALL have port period_valid, output, 1: one-cycle strobe when half_period updates.
REQ-011 SHALL have port lost, output, 1: level, high while the input is declared stopped.

Function
REQ-012 SHALL pass slow_in through SYNC_STAGES flops, then one history flop; edge = synchronized value differs from history.
REQ-013 SHALL register rise_pulse and fall_pulse, asserting them SYNC_STAGES+1 cycles after the slow_in transition.
REQ-014 SHALL never assert rise_pulse and fall_pulse in the same cycle.
REQ-015 SHALL implement FSM states ACQUIRE, RUN and LOST; reset state is ACQUIRE.
REQ-016 In ACQUIRE, an edge SHALL clear the counter, enter RUN and leave period_valid low (no reference edge yet).
REQ-017 In RUN, an edge SHALL load half_period with counter+1, pulse period_valid and clear the counter.
REQ-018 In RUN or ACQUIRE, with no edge and counter == TIMEOUT_CYC-1, the FSM SHALL enter LOST, set lost=1 and hold the counter.
REQ-019 In LOST, an edge SHALL clear lost, clear the counter and enter RUN without pulsing period_valid.
REQ-020 When an edge and the timeout coincide, the edge SHALL win.
REQ-021 SHALL hold half_period at its last value through LOST.
REQ-022 The counter SHALL saturate and never wrap.

Reset
REQ-023 Asserting rst_n low SHALL immediately clear all outputs, the counter and the synchronizer flops, and force ACQUIRE.
REQ-024 Reset mid-measurement SHALL discard the partial count; the first edge after release is treated per REQ-016.
REQ-025 SHALL require rst_n release to be synchronous to clk; the block does not add its own reset synchronizer.

Configuration
REQ-026 With SLOW_CLK_MON_GLITCH_FILTER_EN defined:
- an edge is accepted only after the synchronized level has stayed stable for 2 further cycles;
- shorter glitches are ignored;
- pulse latency becomes SYNC_STAGES+3.
REQ-027 Without SLOW_CLK_MON_GLITCH_FILTER_EN, there SHALL be no filter and latency is per REQ-013.

Structure
REQ-028 Package slow_clk_mon_pkg SHALL hold the FSM state encoding and the default parameter constants.
REQ-029 The synchronizer SHALL be sub-module sync_ff (parameterized depth, asynchronous active-low reset).

Verification
Parameters for all scenarios: SYNC_STAGES=2, TIMEOUT_CYC=40, filter off.
REQ-030 Scenario: slow_in toggles every 10 clk cycles.
- rise_pulse and fall_pulse each appear 3 cycles after their slow_in edge.
- The first edge gives no period_valid.
- Each later edge gives period_valid with half_period=10.
REQ-031 Scenario: slow_in held constant for 40 cycles after the last edge -> lost=1 exactly at the 40th cycle, and half_period keeps 10.
REQ-032 Scenario: from LOST, slow_in resumes toggling every 10 cycles.
- lost clears on the first edge, with no period_valid.
- The next edge gives half_period=10.
REQ-033 Scenario: edge timed to coincide with counter=39 -> no lost assertion, period_valid with half_period=40.
REQ-034 Scenario: rst_n pulsed low mid-count.
- Outputs clear asynchronously.
- The next edge gives no period_valid.
- The following edge gives a correct half_period.
REQ-035 Scenario: with SLOW_CLK_MON_GLITCH_FILTER_EN defined, a 1-cycle high glitch on slow_in -> no rise_pulse, and a real edge gives a pulse 5 cycles later.

Source files
------------

// File: rtl/slow_clk_mon_pkg.sv
// slow_clk_mon_pkg
// Shared definitions for the slow clock monitor:
//   - slow_clk_state_e : FSM state encoding (ACQUIRE, RUN, LOST)
//   - DEF_*            : default values for the monitor parameters
package slow_clk_mon_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        RUN     = 2'd1,
        LOST    = 2'd2
    } slow_clk_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT_CYC = 250000000;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/sync_ff.sv
// sync_ff
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk   - system clock (rising edge)
//   rst_n - asynchronous active-low reset, clears every stage
//   d     - asynchronous input level
//   q     - synchronized level, STAGES cycles behind d
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages;

    // Plain shift chain; only stage 0 may go metastable, later stages give it time to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[STAGES-2:0], d};
        end
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor
// Watches an asynchronous slow square wave, strobes each accepted edge,
// measures the clk-cycle distance between consecutive edges and flags
// the input as lost when no edge arrives within TIMEOUT_CYC cycles.
// Ports:
//   clk          - system clock (rising edge)
//   rst_n        - asynchronous active-low reset (release must be synchronous to clk)
//   slow_in      - asynchronous slow input
//   rise_pulse   - one-cycle strobe per accepted rising edge
//   fall_pulse   - one-cycle strobe per accepted falling edge
//   half_period  - clk cycles between the last two accepted edges
//   period_valid - one-cycle strobe when half_period updates
//   lost         - high while the input is considered stopped
// Build option: SLOW_CLK_MON_GLITCH_FILTER_EN adds a 2-cycle stability
// filter after the synchronizer (pulse latency SYNC_STAGES+3 instead of +1).
module slow_clk_monitor
    import slow_clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             lost
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    logic            sync_q;
    logic            hist;
    logic            edge_det;
    logic            new_level;
    slow_clk_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc, half_d;
    logic            pv_d, lost_d;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (slow_in),
        .q    (sync_q)
    );

`ifdef SLOW_CLK_MON_GLITCH_FILTER_EN
    logic stab1, stab2;
    logic stable;

    // The level is only trusted once sync_q and the two delayed copies agree,
    // so anything shorter than three matching samples never reaches hist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab1 <= 1'b0;
            stab2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            stab1 <= sync_q;
            stab2 <= stab1;
            if (stable) begin
                hist <= stab2;
            end
        end
    end

    assign stable    = (sync_q == stab1) && (stab1 == stab2);
    assign edge_det  = stable && (stab2 != hist);
    assign new_level = stab2;
`else
    // History flop: an edge is simply the synchronized level changing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 1'b0;
        end else begin
            hist <= sync_q;
        end
    end

    assign edge_det  = (sync_q != hist);
    assign new_level = sync_q;
`endif

    // Saturating increment so a stalled count never wraps back to a small value.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    // Next-state and datapath decisions; an edge always takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt;
        half_d  = half_period;
        pv_d    = 1'b0;
        lost_d  = lost;
        case (state_q)
            ACQUIRE: begin
                if (edge_det) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (cnt == TIMEOUT_LAST) begin
                    lost_d  = 1'b1;
                    state_d = LOST;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                if (edge_det) begin
                    half_d = cnt_inc;
                    pv_d   = 1'b1;
                    cnt_d  = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    lost_d  = 1'b1;
                    state_d = LOST;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LOST: begin
                if (edge_det) begin
                    lost_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = ACQUIRE;
            end
        endcase
    end

    // State register plus registered outputs, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACQUIRE;
            cnt          <= '0;
            half_period  <= '0;
            period_valid <= 1'b0;
            lost         <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt          <= cnt_d;
            half_period  <= half_d;
            period_valid <= pv_d;
            lost         <= lost_d;
            rise_pulse   <= edge_det & new_level;
            fall_pulse   <= edge_det & ~new_level;
        end
    end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// tb_slow_clk_monitor
// Self-checking bench for slow_clk_monitor (SYNC_STAGES=2, TIMEOUT_CYC=40).
// Each slow_in toggle pushes the expected edge strobe onto a scoreboard;
// a negedge monitor pops and compares when the DUT strobes.
// Honors SLOW_CLK_MON_GLITCH_FILTER_EN to add the glitch sequence and latency.
module tb_slow_clk_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 40;
    localparam int CNT_W       = 32;
`ifdef SLOW_CLK_MON_GLITCH_FILTER_EN
    localparam int LAT = SYNC_STAGES + 3;
`else
    localparam int LAT = SYNC_STAGES + 1;
`endif

    typedef struct {
        int          gap;
        logic        exp_pv;
        logic [31:0] exp_half;
    } vec_t;

    typedef struct {
        int          due;
        logic        kind;
        logic        pv;
        logic [31:0] half;
    } sb_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             slow_in = 1'b0;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             lost;

    int  cyc = 0;
    int  n_vec = 0;
    int  n_miss = 0;
    int  last_drive = 0;
    int  last_due = 0;
    int  rise_cnt = 0;
    sb_t sb[$];
    vec_t vecs[10];

    slow_clk_monitor #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slow_in     (slow_in),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .half_period (half_period),
        .period_valid(period_valid),
        .lost        (lost)
    );

    // 10 ns clock and a cycle counter used to time every expectation.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flagMiss(input string name);
        n_vec++;
        n_miss++;
        $display("[TB] FAIL %s: got unexpected behaviour, want scoreboard match (cycle %0d)", name, cyc);
    endtask

    // Toggle slow_in gap cycles after the previous toggle and queue the expected strobe.
    task automatic applyStimulus(input int gap, input logic pv, input logic [31:0] half);
        sb_t e;
        int  target;
        target = last_drive + gap;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < target);
        slow_in = ~slow_in;
        e.due  = cyc + LAT;
        e.kind = slow_in;
        e.pv   = pv;
        e.half = half;
        sb.push_back(e);
        last_drive = cyc;
        last_due   = e.due;
    endtask

    // Compare DUT strobes against the scoreboard front entry.
    task automatic checkOutput();
        sb_t e;
        if (rise_pulse || fall_pulse) begin
            rise_cnt += int'(rise_pulse);
            cmp("exclusive_pulses", {31'b0, rise_pulse & fall_pulse}, 32'd0);
            if (sb.size() == 0) begin
                flagMiss("unexpected_pulse");
            end else begin
                e = sb.pop_front();
                cmp("pulse_cycle", cyc, e.due);
                cmp("rise_pulse", {31'b0, rise_pulse}, {31'b0, e.kind});
                cmp("fall_pulse", {31'b0, fall_pulse}, {31'b0, ~e.kind});
                cmp("period_valid", {31'b0, period_valid}, {31'b0, e.pv});
                cmp("half_period", half_period, e.half);
                cmp("lost_at_edge", {31'b0, lost}, 32'd0);
            end
        end else begin
            if (period_valid) begin
                flagMiss("stray_period_valid");
            end
            if (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                flagMiss("missed_pulse");
            end
        end
    endtask

    always @(negedge clk) if (rst_n) checkOutput();

    task automatic waitNeg();
        @(negedge clk);
        #1;
    endtask

    task automatic waitUntil(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 500) begin
            waitNeg();
            guard++;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            waitNeg();
            guard++;
        end
    endtask

    task automatic checkCleared(input string tag);
        cmp({tag, "_rise"}, {31'b0, rise_pulse}, 32'd0);
        cmp({tag, "_fall"}, {31'b0, fall_pulse}, 32'd0);
        cmp({tag, "_pv"}, {31'b0, period_valid}, 32'd0);
        cmp({tag, "_half"}, half_period, 32'd0);
        cmp({tag, "_lost"}, {31'b0, lost}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p;
        int rc;

        // gap between toggles, then expected period_valid and half_period at the strobe
        vecs[0] = '{5,  1'b0, 32'd0};
        vecs[1] = '{10, 1'b1, 32'd10};
        vecs[2] = '{10, 1'b1, 32'd10};
        vecs[3] = '{10, 1'b1, 32'd10};
        vecs[4] = '{7,  1'b1, 32'd7};
        vecs[5] = '{13, 1'b1, 32'd13};
        vecs[6] = '{3,  1'b1, 32'd3};
        vecs[7] = '{40, 1'b1, 32'd40};
        vecs[8] = '{10, 1'b1, 32'd10};
        vecs[9] = '{10, 1'b1, 32'd10};

        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkCleared("reset");
        rst_n = 1'b1;
        last_drive = cyc;

        $display("[TB] periodic toggling and gap table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].gap, vecs[i].exp_pv, vecs[i].exp_half);
        end
        drain();

        $display("[TB] timeout to lost");
        p = last_due;
        waitUntil(p + TIMEOUT_CYC - 1);
        cmp("lost_before_timeout", {31'b0, lost}, 32'd0);
        waitUntil(p + TIMEOUT_CYC);
        cmp("lost_at_timeout", {31'b0, lost}, 32'd1);
        cmp("half_held_in_lost", half_period, 32'd10);

        $display("[TB] resume from lost");
        applyStimulus(48, 1'b0, 32'd10);
        waitUntil(last_due - 1);
        cmp("lost_before_resume_edge", {31'b0, lost}, 32'd1);
        waitUntil(last_due);
        cmp("lost_after_resume_edge", {31'b0, lost}, 32'd0);
        applyStimulus(10, 1'b1, 32'd10);
        drain();

        $display("[TB] reset mid-count");
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkCleared("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_drive = cyc;
        applyStimulus(8, 1'b0, 32'd0);
        applyStimulus(12, 1'b1, 32'd12);

`ifdef SLOW_CLK_MON_GLITCH_FILTER_EN
        $display("[TB] glitch rejection");
        repeat (4) @(posedge clk);
        #1;
        slow_in = 1'b1;
        @(posedge clk);
        #1;
        slow_in = 1'b0;
        drain();
        rc = rise_cnt;
        repeat (10) @(posedge clk);
        #1;
        cmp("glitch_no_rise", rise_cnt, rc);
        applyStimulus(20, 1'b1, 32'd20);
`else
        rc = 0;
`endif
        drain();
        cmp("scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
